// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit path: arbiter FSM state encoding
// (one-hot, same style as the transmitter) and default widths/limits.
// No ports.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_WIDTH_DEF  = 8;
   localparam int WDOG_CYCLES_DEF = 16384;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'b0001,
      ST_LAUNCH    = 4'b0010,
      ST_WAIT_BUSY = 4'b0100,
      ST_WAIT_DONE = 4'b1000
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Returns the first requesting index
// strictly after i_last, wrapping modulo NUM_REQ (any count, not only powers
// of two). i_last itself is the final candidate, so a lone requester is
// re-granted.
// Ports:
//   i_req   [NUM_REQ-1:0] request vector
//   i_last  [IDX_W-1:0]   index granted last
//   o_found               at least one request is set
//   o_idx   [IDX_W-1:0]   selected index (0 when nothing requests)
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic               o_found,
   output logic [IDX_W-1:0]   o_idx
);

   always_comb begin
      logic [IDX_W-1:0] w_cand;
      // NOTE: every variable written here gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      // Scan from the farthest candidate to the nearest; the last hit wins,
      // which leaves the nearest requester after i_last in o_idx.
      for (int off = NUM_REQ; off >= 1; off--) begin
         w_cand = IDX_W'((int'(i_last) + off) % NUM_REQ);
         if (i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Round-robin arbiter/sequencer sharing one uart_tx among NUM_SRC producers.
// One byte in flight at a time: grant -> launch -> wait busy -> wait done.
// Optional watchdog enabled by defining UART_ARB_WDOG_EN; without it arb_err
// is tied low and the block waits for tx_done indefinitely.
// Ports:
//   sysclk, rst         clock, synchronous active-high reset
//   src_req  [N]        per-source request level, held until src_ack
//   src_data [N*DW]     source i byte at [i*DW +: DW]
//   src_ack  [N]        pulse: granted byte captured
//   src_done [N]        pulse: granted byte finished serializing
//   arb_err             pulse: watchdog abort
//   tx_data  [DW]       byte to transmitter, stable launch..done
//   tx_req              one-cycle launch pulse
//   tx_busy, tx_done    transmitter status level / completion pulse
// -----------------------------------------------------------------------------
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
   input  logic                          sysclk,
   input  logic                          rst,
   input  logic [NUM_SRC-1:0]            src_req,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   output logic [NUM_SRC-1:0]            src_ack,
   output logic [NUM_SRC-1:0]            src_done,
   output logic                          arb_err,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_req,
   input  logic                          tx_busy,
   input  logic                          tx_done
);

   localparam int IDX_W = $clog2(NUM_SRC);

   if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_chk_num_src
      $error("uart_tx_arb: NUM_SRC must be in 2..16");
   end
   if (WDOG_CYCLES < 2) begin : g_chk_wdog
      $error("uart_tx_arb: WDOG_CYCLES must be at least 2");
   end

   arb_state_t              r_state;
   arb_state_t              w_next_state;
   logic [IDX_W-1:0]        r_grant;
   logic [IDX_W-1:0]        r_last;
   logic [IDX_W-1:0]        w_pick;
   logic                    w_found;
   logic                    w_grant_go;
   logic                    w_complete;
   logic                    w_abort;
   logic                    w_wdog_hit;
   logic [DATA_WIDTH-1:0]   r_tx_data;
   logic [NUM_SRC-1:0]      r_src_ack;
   logic [NUM_SRC-1:0]      r_src_done;

   rr_pick #(.NUM_REQ(NUM_SRC)) u_rr_pick (
      .i_req   (src_req),
      .i_last  (r_last),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   // State register
   always_ff @(posedge sysclk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Next state and launch strobe
   always_comb begin
      w_next_state = r_state;
      w_grant_go   = 1'b0;
      w_complete   = 1'b0;
      w_abort      = 1'b0;
      tx_req       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Transmitter status is ignored here except to hold off re-grant.
            if (w_found && !tx_busy) begin
               w_grant_go   = 1'b1;
               w_next_state = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            tx_req       = 1'b1;
            w_next_state = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            // A done that overtakes busy still counts as completion.
            if (tx_done) begin
               w_complete   = 1'b1;
               w_next_state = ST_IDLE;
            end else if (w_wdog_hit) begin
               w_abort      = 1'b1;
               w_next_state = ST_IDLE;
            end else if (tx_busy) begin
               w_next_state = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done) begin
               w_complete   = 1'b1;
               w_next_state = ST_IDLE;
            end else if (w_wdog_hit) begin
               w_abort      = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Grant capture, pointer and per-source pulses
   always_ff @(posedge sysclk) begin
      if (rst) begin
         r_grant    <= '0;
         r_last     <= IDX_W'(NUM_SRC - 1);
         r_tx_data  <= '0;
         r_src_ack  <= '0;
         r_src_done <= '0;
      end else begin
         r_src_ack  <= '0;
         r_src_done <= '0;
         if (w_grant_go) begin
            r_grant           <= w_pick;
            r_tx_data         <= src_data[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
            r_src_ack[w_pick] <= 1'b1;
         end
         if (w_complete) begin
            r_src_done[r_grant] <= 1'b1;
            r_last              <= r_grant;
         end
         // An aborted transfer still moves the pointer so the stuck source
         // does not monopolise the next arbitration.
         if (w_abort) r_last <= r_grant;
      end
   end

`ifdef UART_ARB_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES);

   logic [WDOG_W-1:0] r_wdog_cnt;
   logic              r_arb_err;

   // Counts cycles spent in the current wait state; any state change clears it.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         r_wdog_cnt <= '0;
      end else if (w_next_state != r_state) begin
         r_wdog_cnt <= '0;
      end else if (r_state == ST_WAIT_BUSY || r_state == ST_WAIT_DONE) begin
         r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
   end

   assign w_wdog_hit = (r_state == ST_WAIT_BUSY || r_state == ST_WAIT_DONE) &&
                       (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

   always_ff @(posedge sysclk) begin
      if (rst) r_arb_err <= 1'b0;
      else     r_arb_err <= w_abort;
   end

   assign arb_err = r_arb_err;
`else
   assign w_wdog_hit = 1'b0;
   assign arb_err    = 1'b0;
`endif

   assign src_ack  = r_src_ack;
   assign src_done = r_src_done;
   assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
// Self-checking bench for uart_tx_arb with a stub transmitter. A table of
// request vectors with expected grants, hand-written corner sequences (reset
// mid-transfer, continuous requesters, early done, stuck busy) and a random
// phase checked against a round-robin reference model.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int WD = 64;

   logic            sysclk = 1'b0;
   logic            rst    = 1'b1;
   logic [N-1:0]    src_req = '0;
   logic [N*DW-1:0] src_data = '0;
   logic [N-1:0]    src_ack;
   logic [N-1:0]    src_done;
   logic            arb_err;
   logic [DW-1:0]   tx_data;
   logic            tx_req;
   logic            tx_busy;
   logic            tx_done;

   int checks = 0;
   int errors = 0;

   // Stub transmitter controls: 0 normal frame, 1 busy stuck high, 2 done
   // with busy never asserted.
   int   stub_mode    = 0;
   int   frame_len    = 4;
   int   stub_cnt     = 0;
   logic stub_release = 1'b0;
   int   txreq_cnt    = 0;

   logic [7:0] src_bytes [N] = '{8'h3C, 8'h5A, 8'hA5, 8'hC3};

   always #5 sysclk = ~sysclk;

   uart_tx_arb #(.NUM_SRC(N), .DATA_WIDTH(DW), .WDOG_CYCLES(WD)) dut (
      .sysclk   (sysclk),
      .rst      (rst),
      .src_req  (src_req),
      .src_data (src_data),
      .src_ack  (src_ack),
      .src_done (src_done),
      .arb_err  (arb_err),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   // Stub transmitter, synchronous like the real uart_tx
   always @(posedge sysclk) begin
      if (rst) begin
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         stub_cnt <= 0;
      end else begin
         tx_done <= 1'b0;
         if (tx_req) begin
            if (stub_mode == 0) begin
               tx_busy  <= 1'b1;
               stub_cnt <= frame_len;
            end else if (stub_mode == 1) begin
               tx_busy <= 1'b1;
            end else begin
               stub_cnt <= 3;
            end
         end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
               tx_done <= 1'b1;
               tx_busy <= 1'b0;
            end
         end
         if (stub_mode == 1 && stub_release) tx_busy <= 1'b0;
      end
   end

   // A launch must never land on a transmitter that is still busy.
   always @(negedge sysclk) begin
      if (!rst && tx_req) begin
         txreq_cnt++;
         checks++;
         if (tx_busy) begin
            errors++;
            $display("FAIL tx_req_while_busy: tx_req=1 with tx_busy=1 at %0t", $time);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference rule: first requester after the last grant, wrapping.
   function automatic int model_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         if (req[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic load_bytes();
      for (int s = 0; s < N; s++) src_data[s*DW +: DW] = src_bytes[s];
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      rst     = 1'b1;
      src_req = '0;
      repeat (2) @(negedge sysclk);
      rst = 1'b0;
   endtask

   // Drive a request in IDLE and expect ack/launch on the very next cycle.
   task automatic apply_req(input string nm, input logic [N-1:0] req, input int idx);
      src_req = req;
      @(negedge sysclk);
      check({nm, "_ack"}, 32'(src_ack), 32'd1 << idx);
      check({nm, "_tx_req"}, 32'(tx_req), 32'd1);
      check({nm, "_tx_data"}, 32'(tx_data), 32'(src_data[idx*DW +: DW]));
      src_req = '0;
   endtask

   // Wait (bounded) for the frame to end; src_done must follow tx_done by one cycle.
   task automatic finish_frame(input string nm, input int idx, input logic [7:0] b);
      bit seen = 1'b0;
      bit held = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge sysclk);
         if (tx_data !== b) held = 1'b0;
         if (tx_done) begin
            seen = 1'b1;
            break;
         end
      end
      check({nm, "_hold"}, 32'(held), 32'd1);
      check({nm, "_done_seen"}, 32'(seen), 32'd1);
      @(negedge sysclk);
      check({nm, "_src_done"}, 32'(src_done), 32'd1 << idx);
   endtask

   task automatic wait_ack(output logic [N-1:0] a);
      a = '0;
      for (int k = 0; k < 200; k++) begin
         @(negedge sysclk);
         if (src_ack != '0) begin
            a = src_ack;
            break;
         end
      end
   endtask

   typedef struct {
      logic [N-1:0] req;
      int           exp_idx;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [N-1:0] a;
      int           base_cnt;
      int           err_cnt;
      int           done_cnt;
      int           ack_cnt;
      bit           busy_seen;
      bit           quiet;
      int           model_last;
      int           pend_idx;
      logic [7:0]   pend_byte;
      int           served;
      int           hold_bad;
      int           exp;
      int           exp_order [6];

      // Pointer starts at 3 after reset; each row chains from the previous grant.
      vecs[0] = '{4'b0100, 2};
      vecs[1] = '{4'b1111, 3};
      vecs[2] = '{4'b1001, 0};
      vecs[3] = '{4'b1001, 3};
      vecs[4] = '{4'b0010, 1};
      vecs[5] = '{4'b0011, 0};
      vecs[6] = '{4'b1000, 3};
      vecs[7] = '{4'b1000, 3};
      vecs[8] = '{4'b0110, 1};
      vecs[9] = '{4'b0101, 2};

      load_bytes();
      do_reset();
      check("reset_outputs", 32'({src_ack, src_done, arb_err, tx_req, tx_data}), 32'd0);
      @(negedge sysclk);
      check("idle_outputs", 32'({src_ack, src_done, arb_err, tx_req, tx_data}), 32'd0);

      // Table: grant order, one-cycle ack, byte capture, done timing
      frame_len = 4;
      for (int i = 0; i < 10; i++) begin
         apply_req($sformatf("vec%0d", i), vecs[i].req, vecs[i].exp_idx);
         finish_frame($sformatf("vec%0d", i), vecs[i].exp_idx, src_bytes[vecs[i].exp_idx]);
      end

      // Reset in WAIT_DONE: pointer last sat at 2, reset must put it back to 3
      frame_len = 20;
      apply_req("midrst", 4'b0010, 1);
      repeat (6) @(negedge sysclk);
      rst = 1'b1;
      @(negedge sysclk);
      check("midrst_outputs", 32'({src_ack, src_done, arb_err, tx_req, tx_data}), 32'd0);
      rst = 1'b0;
      quiet = 1'b1;
      repeat (25) begin
         @(negedge sysclk);
         if (src_done != '0 || arb_err) quiet = 1'b0;
      end
      check("midrst_no_pulses", 32'(quiet), 32'd1);

      // All four requesting continuously: 0,1,2,3,0,1 and one launch per frame
      frame_len = 4;
      base_cnt  = txreq_cnt;
      exp_order = '{0, 1, 2, 3, 0, 1};
      src_req   = 4'b1111;
      @(negedge sysclk);
      check("all_grant0", 32'(src_ack), 32'd1);
      for (int g = 1; g < 6; g++) begin
         wait_ack(a);
         check($sformatf("all_grant%0d", g), 32'(a), 32'd1 << exp_order[g]);
      end
      src_req = '0;
      finish_frame("all_last", 1, src_bytes[1]);
      check("all_launch_count", 32'(txreq_cnt - base_cnt), 32'd6);

      // Early done: completion without busy ever rising
      stub_mode = 2;
      apply_req("early", 4'b0100, 2);
      busy_seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge sysclk);
         if (tx_busy) busy_seen = 1'b1;
         if (tx_done) break;
      end
      check("early_busy_never", 32'(busy_seen), 32'd0);
      @(negedge sysclk);
      check("early_src_done", 32'(src_done), 32'b0100);
      apply_req("early_next", 4'b1000, 3);
      finish_frame("early_next", 3, src_bytes[3]);

      // Busy stuck high, no done
      stub_mode = 1;
      apply_req("stuck", 4'b0001, 0);
      src_req  = 4'b1110;
      err_cnt  = 0;
      done_cnt = 0;
      ack_cnt  = 0;
      repeat (WD + 40) begin
         @(negedge sysclk);
         if (arb_err) err_cnt++;
         if (src_done != '0) done_cnt++;
         if (src_ack != '0) ack_cnt++;
      end
`ifdef UART_ARB_WDOG_EN
      check("wdog_err_pulses", 32'(err_cnt), 32'd1);
      check("wdog_no_done", 32'(done_cnt), 32'd0);
      check("wdog_no_regrant_busy", 32'(ack_cnt), 32'd0);
      stub_release = 1'b1;
      wait_ack(a);
      check("wdog_regrant", 32'(a), 32'b0010);
`else
      check("stuck_no_err", 32'(err_cnt), 32'd0);
      check("stuck_no_done", 32'(done_cnt), 32'd0);
      check("stuck_no_regrant", 32'(ack_cnt), 32'd0);
`endif
      stub_release = 1'b0;
      stub_mode    = 0;
      do_reset();

      // Random traffic against the reference model
      model_last = N - 1;
      pend_idx   = -1;
      pend_byte  = '0;
      served     = 0;
      hold_bad   = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge sysclk);
         if (src_done != '0) begin
            check("rand_done", 32'(src_done), (pend_idx >= 0) ? (32'd1 << pend_idx) : 32'd0);
            if (pend_idx >= 0) model_last = pend_idx;
            pend_idx = -1;
            served++;
         end
         if (src_ack != '0) begin
            exp = model_pick(src_req, model_last);
            check("rand_ack", 32'(src_ack), (exp >= 0) ? (32'd1 << exp) : 32'd0);
            if (exp >= 0) begin
               check("rand_tx_data", 32'(tx_data), 32'(src_data[exp*DW +: DW]));
               pend_idx     = exp;
               pend_byte    = src_data[exp*DW +: DW];
               src_req[exp] = 1'b0;
            end
            frame_len = int'($urandom_range(1, 6));
         end
         if (pend_idx >= 0 && tx_data !== pend_byte) hold_bad++;
         if (cyc < 2700) begin
            for (int s = 0; s < N; s++) begin
               if (!src_req[s] && $urandom_range(0, 7) == 0) begin
                  src_data[s*DW +: DW] = 8'($urandom);
                  src_req[s] = 1'b1;
               end
            end
         end
      end
      check("rand_drained", 32'(src_req), 32'd0);
      check("rand_hold", 32'(hold_bad), 32'd0);
      check("rand_served", 32'(served > 50), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
